// File: rtl/mul16_pkg.sv
// Shared constants and types for the mul16_seq shift-add multiplier.
package mul16_pkg;

  localparam logic [1:0] MUL_IDLE  = 2'd0;
  localparam logic [1:0] MUL_BUSY  = 2'd1;
  localparam logic [1:0] MUL_DONE  = 2'd2;
  localparam int         MUL_STEPS = 16;

  typedef enum logic [1:0] {
    ST_IDLE = MUL_IDLE,
    ST_BUSY = MUL_BUSY,
    ST_DONE = MUL_DONE
  } mul_state_e;

  // Magnitude of a 16-bit two's-complement value; 0x8000 maps to 0x8000 unsigned.
  function automatic logic [15:0] abs16(input logic [15:0] v);
    return v[15] ? (~v + 16'd1) : v;
  endfunction

endpackage

// File: rtl/mul16_seq_if.sv
// Operand/result handshake bundle for mul16_seq; slave is the multiplier side.
interface mul16_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/mul16_seq_add16_co.sv
// 16-bit ripple adder from a FullAdder chain, exposing the carry-out as bit 17.
module FullAdder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);
  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

module add16_co (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_ci,
  output logic [15:0] o_s,
  output logic        o_co
);
  logic [16:0] w_c;

  assign w_c[0] = i_ci;
  assign o_co   = w_c[16];

  for (genvar g = 0; g < 16; g++) begin : g_fa
    FullAdder u_fa (
      .i_a (i_a[g]),
      .i_b (i_b[g]),
      .i_ci(w_c[g]),
      .o_s (o_s[g]),
      .o_co(w_c[g+1])
    );
  end
endmodule

// File: rtl/mul16_seq.sv
// Iterative 16x16->32 shift-add multiplier, one conditional add + shift per cycle.
// Define MUL16_SIGNED_EN to treat a/b as two's-complement signed operands.
module mul16_seq
  import mul16_pkg::*;
#(
  parameter bit ZERO_SHORTCUT = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  mul16_seq_if.slave     bus
);

  mul_state_e  r_state, w_next;
  logic [15:0] r_hi, r_lo, r_areg;
  logic [3:0]  r_cnt;
  logic [31:0] r_product;

  logic        w_accept, w_zero, w_last, w_co;
  logic [15:0] w_addend, w_sum16, w_a_in, w_b_in;
  logic [31:0] w_raw, w_final;

  assign w_accept = (r_state == ST_IDLE) && bus.in_valid;
  assign w_zero   = ZERO_SHORTCUT && ((bus.a == 16'd0) || (bus.b == 16'd0));
  assign w_last   = (r_cnt == 4'(MUL_STEPS - 1));
  assign w_addend = r_lo[0] ? r_areg : 16'd0;

  add16_co u_add (
    .i_a (r_hi),
    .i_b (w_addend),
    .i_ci(1'b0),
    .o_s (w_sum16),
    .o_co(w_co)
  );

  // {hi,lo} after this step's shift: {sum[16:0], lo[15:1]}
  assign w_raw = {w_co, w_sum16, r_lo[15:1]};

`ifdef MUL16_SIGNED_EN
  logic r_neg;
  assign w_a_in  = abs16(bus.a);
  assign w_b_in  = abs16(bus.b);
  assign w_final = r_neg ? (~w_raw + 32'd1) : w_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_neg <= 1'b0;
    else if (w_accept) r_neg <= bus.a[15] ^ bus.b[15];
  end
`else
  assign w_a_in  = bus.a;
  assign w_b_in  = bus.b;
  assign w_final = w_raw;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = w_zero ? ST_DONE : ST_BUSY;
      ST_BUSY: if (w_last)   w_next = ST_DONE;
      ST_DONE: if (bus.out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_areg    <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_areg <= w_a_in;
          r_hi   <= '0;
          r_lo   <= w_b_in;
          r_cnt  <= '0;
          if (w_zero) r_product <= '0;
        end
        ST_BUSY: begin
          r_hi  <= w_raw[31:16];
          r_lo  <= w_raw[15:0];
          r_cnt <= r_cnt + 4'd1;
          if (w_last) r_product <= w_final;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE) && !rst;
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.busy      = (r_state == ST_BUSY);
  assign bus.product   = r_product;

endmodule
